wb_cmd_sequencer: RTL and testbench
===================================

WB_CMD_SEQUENCER -- requirements
Module: wb_cmd_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 256, max bus cycles waited for ack/err before abort.
REQ-003 SHALL have parameter ADDR_INC, default 4, address post-increment after each acked R/W.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_word  in  34  command: [33:32] opcode (00=R, 01=W, 10=A, 11=S), [31:0] payload.
REQ-007 cmd_valid  in  1  one-cycle strobe qualifying cmd_word; no backpressure exists upstream.
REQ-008 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone classic master controls.
REQ-009 wb_adr_o  out  32  bus address; wb_dat_o out 32 write data; wb_sel_o out 4 byte selects.
REQ-010 wb_dat_i  in  32  read data; wb_ack_i, wb_err_i  in  1 each  slave termination.
REQ-011 rsp_valid  out  1  one-cycle strobe per completed R or W.
REQ-012 rsp_data  out  32  read data (R), 0 for W; rsp_we out 1 (1=W); rsp_err out 1 (err or timeout).
REQ-013 ovf  out  1  sticky: a command was dropped on a full FIFO.
REQ-014 busy  out  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-015 cmd_valid with FIFO not full SHALL push cmd_word; when full the word SHALL be dropped and ovf set, regardless of a same-cycle pop.
REQ-016 FSM states: IDLE, BUS, RESP; all outputs registered.
REQ-017 IDLE, FIFO non-empty: pop one entry per cycle; A loads addr_r <= payload; S loads sel_r <= payload[3:0]; both stay IDLE.
REQ-018 IDLE, popped R/W: next cycle BUS with cyc=stb=1, we=(W), adr=addr_r, sel=sel_r, dat_o=payload (W) else 0.
REQ-019 BUS: cyc/stb/adr/we/dat_o/sel SHALL stay stable until termination; timeout counter starts at 0 on BUS entry and increments every cycle.
REQ-020 BUS, wb_ack_i=1: cyc/stb drop next cycle, capture wb_dat_i (R), rsp_err=0, addr_r += ADDR_INC (mod 2^32), go RESP.
REQ-021 BUS, wb_err_i=1 (priority over ack if both high): terminate as REQ-020 but rsp_err=1, rsp_data=0, addr_r unchanged.
REQ-022 BUS, counter reaching TIMEOUT-1 without ack/err: abort, cyc/stb drop next cycle, rsp_err=1, rsp_data=0, addr_r unchanged.
REQ-023 RESP: rsp_valid=1 for exactly one cycle with rsp_data/rsp_we/rsp_err; next state IDLE; no pop in RESP.
REQ-024 Minimum latency pop(R/W) -> cyc asserted 1 cycle; ack -> rsp_valid 1 cycle; back-to-back R/W SHALL have >=2 idle bus cycles between cycles.
REQ-025 cmd_valid during BUS/RESP SHALL still push (FIFO buffers up to FIFO_DEPTH).
REQ-026 ack/err seen outside BUS SHALL be ignored.
REQ-027 rsp_data/rsp_we/rsp_err SHALL hold last value when rsp_valid=0.

Reset
REQ-028 rst SHALL immediately (asynchronously) force: FSM IDLE, FIFO empty, cyc/stb/we=0, adr/dat_o=0, sel_r and wb_sel_o=4'hF, addr_r=0, rsp_valid=0, rsp_data=0, rsp_we=0, rsp_err=0, ovf=0, busy=0, timeout counter 0.
REQ-029 rst asserted mid-bus-cycle SHALL drop cyc/stb without a response; the in-flight command is discarded.

Verification
REQ-030 A 0x1000, W 0xDEADBEEF, ack after 3 cycles -> single write adr 0x1000 sel F dat DEADBEEF; rsp_valid rsp_we=1 rsp_err=0; addr_r=0x1004.
REQ-031 A 0x20, R, R with slave returning 0x11, 0x22 -> reads at 0x20 then 0x24; rsp_data 0x11 then 0x22, rsp_we=0.
REQ-032 S 0x3, W 0x55 -> wb_sel_o=4'h3 during the write.
REQ-033 R with no ack (TIMEOUT=16) -> cyc held exactly 16 cycles, then rsp_err=1, rsp_data=0, addr_r unchanged.
REQ-034 Six cmd_valid strobes back-to-back while slave stalls (FIFO_DEPTH=4) -> first R enters BUS, next 4 buffered, sixth dropped, ovf=1 until rst.
REQ-035 rst pulse while cyc=1 -> cyc/stb low asynchronously, no rsp_valid, FIFO empty, sel=F after release.

Source files
------------

// File: rtl/wb_cmd_sequencer_if.sv
// Command, response and Wishbone classic master signals of wb_cmd_sequencer.
// The master modport is the sequencer side; the slave modport is the environment side.
interface wb_cmd_sequencer_if;
  logic [33:0] cmd_word;
  logic        cmd_valid;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_we;
  logic        rsp_err;
  logic        ovf;
  logic        busy;

  modport master (
    input  cmd_word, cmd_valid, wb_dat_i, wb_ack_i, wb_err_i,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output rsp_valid, rsp_data, rsp_we, rsp_err, ovf, busy
  );

  modport slave (
    output cmd_word, cmd_valid, wb_dat_i, wb_ack_i, wb_err_i,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  rsp_valid, rsp_data, rsp_we, rsp_err, ovf, busy
  );
endinterface

// File: rtl/wb_cmd_sequencer.sv
// Buffers 34-bit commands and replays R/W ones as single Wishbone classic cycles;
// A/S commands update the address / byte-select registers. All outputs are registered.
module wb_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 256,
  parameter int ADDR_INC   = 4
) (
  input logic clk,
  input logic rst,
  wb_cmd_sequencer_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = FIFO_DEPTH[AW:0];
  localparam logic [TW-1:0] TCNT_ONE = 1;
  localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT - 1);
  localparam logic [1:0] OP_R = 2'b00, OP_W = 2'b01, OP_A = 2'b10, OP_S = 2'b11;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state, state_nx;

  logic [33:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_nx;
  logic          full, empty, push, pop;
  logic [1:0]    head_op;
  logic [31:0]   head_pl;

  logic          cyc, cyc_d, we, we_d;
  logic [31:0]   adr, adr_d, dat, dat_d;
  logic [3:0]    sel_o, sel_o_d, sel_r, sel_r_d;
  logic [31:0]   addr_r, addr_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic          rsp_valid, rsp_valid_d, rsp_we, rsp_we_d, rsp_err, rsp_err_d;
  logic [31:0]   rsp_data, rsp_data_d;
  logic          ovf, ovf_d, busy, busy_d;
  logic          timed_out, term;

  // Full is judged on the current occupancy only, so a same-cycle pop never rescues a push.
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign push    = bus.cmd_valid && !full;
  assign pop     = (state == IDLE) && !empty;
  assign head_op = mem[rptr][33:32];
  assign head_pl = mem[rptr][31:0];

  assign timed_out = (tcnt == TCNT_MAX);
  assign term      = bus.wb_err_i || bus.wb_ack_i || timed_out;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.cmd_word;
  end

  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + CNT_ONE;
      2'b01:   count_nx = count - CNT_ONE;
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      cyc       <= 1'b0;
      we        <= 1'b0;
      adr       <= '0;
      dat       <= '0;
      sel_o     <= 4'hF;
      sel_r     <= 4'hF;
      addr_r    <= '0;
      tcnt      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_we    <= 1'b0;
      rsp_err   <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count     <= count_nx;
      cyc       <= cyc_d;
      we        <= we_d;
      adr       <= adr_d;
      dat       <= dat_d;
      sel_o     <= sel_o_d;
      sel_r     <= sel_r_d;
      addr_r    <= addr_d;
      tcnt      <= tcnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_we    <= rsp_we_d;
      rsp_err   <= rsp_err_d;
      ovf       <= ovf_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pop && (head_op == OP_R || head_op == OP_W)) state_nx = BUS;
      BUS:     if (term) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cyc_d       = cyc;
    we_d        = we;
    adr_d       = adr;
    dat_d       = dat;
    sel_o_d     = sel_o;
    sel_r_d     = sel_r;
    addr_d      = addr_r;
    tcnt_d      = tcnt;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    rsp_we_d    = rsp_we;
    rsp_err_d   = rsp_err;
    ovf_d       = ovf || (bus.cmd_valid && full);
    case (state)
      IDLE: begin
        if (pop) begin
          case (head_op)
            OP_A: addr_d  = head_pl;
            OP_S: sel_r_d = head_pl[3:0];
            default: begin
              cyc_d   = 1'b1;
              we_d    = (head_op == OP_W);
              adr_d   = addr_r;
              sel_o_d = sel_r;
              dat_d   = (head_op == OP_W) ? head_pl : 32'h0;
              tcnt_d  = '0;
            end
          endcase
        end
      end
      BUS: begin
        tcnt_d = tcnt + TCNT_ONE;
        if (term) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_we_d    = we;
          // Error wins over a simultaneous ack; only a clean ack advances the address.
          if (!bus.wb_err_i && bus.wb_ack_i) begin
            rsp_err_d  = 1'b0;
            rsp_data_d = we ? 32'h0 : bus.wb_dat_i;
            addr_d     = addr_r + 32'(ADDR_INC);
          end else begin
            rsp_err_d  = 1'b1;
            rsp_data_d = 32'h0;
          end
        end
      end
      default: ;
    endcase
    busy_d = (count_nx != '0) || (state_nx != IDLE);
  end

  assign bus.wb_cyc_o  = cyc;
  assign bus.wb_stb_o  = cyc;
  assign bus.wb_we_o   = we;
  assign bus.wb_adr_o  = adr;
  assign bus.wb_dat_o  = dat;
  assign bus.wb_sel_o  = sel_o;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_we    = rsp_we;
  assign bus.rsp_err   = rsp_err;
  assign bus.ovf       = ovf;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// Scoreboard bench: stimulus pushes expected bus cycles and responses; monitors pop and compare.
module tb_wb_cmd_sequencer;
  localparam int FD  = 4;
  localparam int TO  = 16;
  localparam int INC = 4;
  localparam logic [1:0] OP_R = 2'b00, OP_W = 2'b01, OP_A = 2'b10, OP_S = 2'b11;

  typedef enum int {K_ACK, K_ERR, K_TO} kind_t;
  typedef struct {kind_t kind; int dly; logic [31:0] rdata;} plan_t;
  typedef struct {logic [31:0] adr; logic [31:0] dat; logic we; logic [3:0] sel; int len;} bus_t;
  typedef struct {logic [31:0] data; logic we; logic err;} rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   stray_en = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  plan_t plan_q[$];
  bus_t  bus_q[$];
  rsp_t  rsp_q[$];
  logic [31:0] m_addr = 32'h0;
  logic [3:0]  m_sel  = 4'hF;

  always #5 clk = ~clk;

  wb_cmd_sequencer_if bus ();

  wb_cmd_sequencer #(.FIFO_DEPTH(FD), .TIMEOUT(TO), .ADDR_INC(INC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // mode: 0 = command is dropped/discarded, 1 = normal, 2 = bus cycle killed by reset (no response)
  task automatic send(logic [1:0] op, logic [31:0] pl, kind_t k, int d, logic [31:0] rd, int mode);
    plan_t p;
    bus_t  b;
    rsp_t  r;
    bus.cmd_word  = {op, pl};
    bus.cmd_valid = 1'b1;
    if (mode != 0) begin
      case (op)
        OP_A: m_addr = pl;
        OP_S: m_sel  = pl[3:0];
        default: begin
          p.kind = k; p.dly = d; p.rdata = rd;
          plan_q.push_back(p);
          b.adr = m_addr; b.we = (op == OP_W); b.sel = m_sel;
          b.dat = (op == OP_W) ? pl : 32'h0;
          b.len = (k == K_TO) ? TO : d + 1;
          bus_q.push_back(b);
          if (mode == 1) begin
            r.data = (k == K_ACK && op == OP_R) ? rd : 32'h0;
            r.we   = (op == OP_W);
            r.err  = (k != K_ACK);
            rsp_q.push_back(r);
            if (k == K_ACK) m_addr = m_addr + 32'(INC);
          end
        end
      endcase
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.rsp_valid) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait_expired", n < 2000, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Slave: acks/errors at the planned cycle of each bus cycle, stray terminations when idle.
  initial begin
    bit    active = 1'b0;
    int    c = 0;
    plan_t cur;
    cur.kind = K_TO; cur.dly = 0; cur.rdata = 32'h0;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      bus.wb_dat_i = $urandom;
      if (rst) begin
        active = 1'b0;
      end else if (bus.wb_cyc_o) begin
        if (!active) begin
          active = 1'b1;
          c = 0;
          if (plan_q.size() > 0) cur = plan_q.pop_front();
          else begin cur.kind = K_TO; cur.dly = 0; cur.rdata = 32'h0; end
        end else begin
          c++;
        end
        if (cur.kind != K_TO && c == cur.dly) begin
          if (cur.kind == K_ACK) begin
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = cur.rdata;
          end else begin
            bus.wb_err_i = 1'b1;
            bus.wb_ack_i = 1'($urandom_range(1));
          end
        end
      end else begin
        active = 1'b0;
        if (stray_en && $urandom_range(7) == 0) begin
          if ($urandom_range(1) == 1) bus.wb_ack_i = 1'b1;
          else bus.wb_err_i = 1'b1;
        end
      end
    end
  end

  // Bus monitor: attributes, stability, length and idle gap of each cycle.
  initial begin
    bit   prev = 1'b0;
    bit   have = 1'b0;
    bit   stable = 1'b1;
    int   len = 0;
    int   gap = 100;
    bus_t cur;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0; have = 1'b0; gap = 100;
        continue;
      end
      if (bus.wb_cyc_o && !prev) begin
        check("bus_idle_gap", gap >= 2, 1);
        if (bus_q.size() == 0) begin
          nchk++; nerr++; have = 1'b0;
          $display("FAIL bus_unexpected: cycle at adr %0h, none expected", bus.wb_adr_o);
        end else begin
          cur = bus_q.pop_front();
          have = 1'b1;
          check("bus_adr", bus.wb_adr_o, cur.adr);
          check("bus_we",  bus.wb_we_o,  cur.we);
          check("bus_sel", bus.wb_sel_o, cur.sel);
          check("bus_dat", bus.wb_dat_o, cur.dat);
          check("bus_stb", bus.wb_stb_o, 1);
        end
        len = 1;
        stable = 1'b1;
      end else if (bus.wb_cyc_o) begin
        len++;
        if (have && (bus.wb_adr_o !== cur.adr || bus.wb_we_o !== cur.we || bus.wb_sel_o !== cur.sel
                     || bus.wb_dat_o !== cur.dat || bus.wb_stb_o !== 1'b1)) stable = 1'b0;
      end else if (prev) begin
        if (have) begin
          check("bus_len", len, cur.len);
          check("bus_stable", stable, 1);
          check("bus_stb_drop", bus.wb_stb_o, 0);
        end
        gap = 1;
      end else if (gap < 100) begin
        gap++;
      end
      prev = bus.wb_cyc_o;
    end
  end

  // Response monitor: single-cycle strobe, payload, and hold when idle.
  initial begin
    bit          prevv = 1'b0;
    logic [31:0] ld = 32'h0;
    logic        lwe = 1'b0;
    logic        lerr = 1'b0;
    rsp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevv = 1'b0; ld = 32'h0; lwe = 1'b0; lerr = 1'b0;
        continue;
      end
      if (bus.rsp_valid) begin
        check("rsp_single_cycle", prevv, 0);
        if (rsp_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL rsp_unexpected: data %0h we %0b err %0b", bus.rsp_data, bus.rsp_we, bus.rsp_err);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_we",   bus.rsp_we,   e.we);
          check("rsp_err",  bus.rsp_err,  e.err);
        end
        ld = bus.rsp_data; lwe = bus.rsp_we; lerr = bus.rsp_err;
      end else begin
        check("rsp_hold", {bus.rsp_data, bus.rsp_we, bus.rsp_err}, {ld, lwe, lerr});
      end
      prevv = bus.rsp_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cyc",       bus.wb_cyc_o,  0);
    check("rst_stb",       bus.wb_stb_o,  0);
    check("rst_we",        bus.wb_we_o,   0);
    check("rst_adr",       bus.wb_adr_o,  0);
    check("rst_dat",       bus.wb_dat_o,  0);
    check("rst_sel",       bus.wb_sel_o,  4'hF);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data",  bus.rsp_data,  0);
    check("rst_rsp_flags", {bus.rsp_we, bus.rsp_err}, 0);
    check("rst_ovf",       bus.ovf,       0);
    check("rst_busy",      bus.busy,      0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(OP_A, 32'h1000, K_ACK, 0, 0, 1);
    send(OP_W, 32'hDEADBEEF, K_ACK, 3, 0, 1);
    wait_idle();
    send(OP_R, 32'h0, K_ACK, 0, 32'h5A5A, 1);  // lands at 0x1004
    wait_idle();

    send(OP_A, 32'h20, K_ACK, 0, 0, 1);
    send(OP_R, 32'h0, K_ACK, 1, 32'h11, 1);
    send(OP_R, 32'h0, K_ACK, 0, 32'h22, 1);
    wait_idle();

    send(OP_S, 32'h3, K_ACK, 0, 0, 1);
    send(OP_W, 32'h55, K_ACK, 2, 0, 1);
    wait_idle();

    send(OP_R, 32'h0, K_TO, 0, 0, 1);
    send(OP_R, 32'h0, K_ACK, 0, 32'hABC, 1);
    send(OP_W, 32'h77, K_ERR, 4, 0, 1);
    send(OP_R, 32'h0, K_ACK, 1, 32'h123, 1);
    wait_idle();

    send(OP_R, 32'h0, K_TO, 0, 0, 1);
    send(OP_W, 32'h1, K_ACK, 1, 0, 1);
    send(OP_R, 32'h0, K_ERR, 2, 0, 1);
    send(OP_A, 32'h400, K_ACK, 0, 0, 1);
    send(OP_R, 32'h0, K_ACK, 0, 32'h77, 1);
    check("ovf_before_drop", bus.ovf, 0);
    send(OP_W, 32'hBAD, K_ACK, 0, 0, 0);
    check("ovf_after_drop", bus.ovf, 1);
    wait_idle();
    check("ovf_sticky", bus.ovf, 1);

    stray_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int n;
      n = $urandom_range(FD, 1);
      for (int j = 0; j < n; j++) begin
        logic [1:0] op;
        int    pick;
        kind_t k;
        op   = 2'($urandom_range(3));
        pick = $urandom_range(9);
        k    = (pick < 7) ? K_ACK : (pick < 9) ? K_ERR : K_TO;
        send(op, $urandom, k, $urandom_range(6), $urandom, 1);
      end
      wait_idle();
    end
    stray_en = 1'b0;

    begin
      int n = 0;
      send(OP_R, 32'h0, K_TO, 0, 0, 2);
      send(OP_W, 32'hCAFE, K_ACK, 0, 0, 0);
      send(OP_S, 32'h1, K_ACK, 0, 0, 0);
      while (!bus.wb_cyc_o && n < 50) begin @(posedge clk); #1; n++; end
      check("abort_cyc_seen", bus.wb_cyc_o, 1);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("abort_cyc_async", bus.wb_cyc_o, 0);
      check("abort_stb_async", bus.wb_stb_o, 0);
      @(negedge clk);
      @(negedge clk);
      check("abort_ovf_clear", bus.ovf, 0);
      rst = 1'b0;
      m_addr = 32'h0;
      m_sel  = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_busy", bus.busy, 0);
      check("abort_sel",  bus.wb_sel_o, 4'hF);
      check("abort_cyc_idle", bus.wb_cyc_o, 0);
    end
    send(OP_R, 32'h0, K_ACK, 1, 32'h99, 1);
    wait_idle();

    repeat (5) @(negedge clk);
    check("left_bus_q",  bus_q.size(),  0);
    check("left_rsp_q",  rsp_q.size(),  0);
    check("left_plan_q", plan_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
